plic_irq_gateway: RTL and testbench



---
 rtl/plic_irq_gateway.sv | 158 +++++++++++++++
 tb/tb_plic_irq_gateway.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/plic_irq_gateway.sv
// plic_irq_gateway: interrupt gateway between raw peripheral interrupt sources
// and the PLIC source lines. Each source is synchronised, optionally converted
// to rising-edge requests with a saturating pending counter, and held high on
// its PLIC line until the PLIC completes that line.
//
// Ports:
//   clock_i           system clock
//   reset_ni          asynchronous active-low reset
//   irq_src_i         raw (possibly asynchronous) source requests, one per source
//   irq_enable_i      per-source enable; gates new requests only
//   plic_irq_o        registered PLIC request lines; source i drives SRC_BASE_LINE+i
//   complete_valid_i  one-cycle PLIC completion strobe
//   complete_id_i     completed PLIC line index
//   overflow_o        sticky per-source flag: an edge was lost at saturation
//   overflow_clear_i  clears all overflow_o bits (a coincident new overflow wins)
module plic_irq_gateway #(
  parameter int unsigned           NUM_SRC        = 4,
  parameter int unsigned           NUM_PLIC_LINES = 32,
  parameter int unsigned           SRC_BASE_LINE  = 1,
  parameter logic [NUM_SRC-1:0]    EDGE_MASK      = '0,
  parameter int unsigned           SYNC_STAGES    = 2,
  parameter int unsigned           MAX_PENDING    = 3
) (
  input  logic                              clock_i,
  input  logic                              reset_ni,
  input  logic [NUM_SRC-1:0]                irq_src_i,
  input  logic [NUM_SRC-1:0]                irq_enable_i,
  output logic [NUM_PLIC_LINES-1:0]         plic_irq_o,
  input  logic                              complete_valid_i,
  input  logic [$clog2(NUM_PLIC_LINES)-1:0] complete_id_i,
  output logic [NUM_SRC-1:0]                overflow_o,
  input  logic                              overflow_clear_i
);

  localparam int unsigned IDW = $clog2(NUM_PLIC_LINES);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  // Parameter sanity checks
  if (SRC_BASE_LINE < 1) begin : g_err_base
    $error("plic_irq_gateway: SRC_BASE_LINE must be >= 1 (line 0 is reserved)");
  end
  if (SRC_BASE_LINE + NUM_SRC > NUM_PLIC_LINES) begin : g_err_range
    $error("plic_irq_gateway: sources do not fit in NUM_PLIC_LINES");
  end
  if (SYNC_STAGES < 1) begin : g_err_sync
    $error("plic_irq_gateway: SYNC_STAGES must be >= 1");
  end
  if (MAX_PENDING < 1) begin : g_err_pend
    $error("plic_irq_gateway: MAX_PENDING must be >= 1");
  end

  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] ovf_set_c;
  logic [NUM_SRC-1:0] overflow_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic                   done_c;
    state_e                 state_q, state_d;

    // Synchroniser: shift in at bit 0, oldest sample at the top
    always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) sync_q <= '0;
      else           sync_q <= SYNC_STAGES'({sync_q, irq_src_i[i]});
    end

    assign sync_s    = sync_q[SYNC_STAGES-1];
    assign done_c    = complete_valid_i && (complete_id_i == IDW'(SRC_BASE_LINE + i));
    assign active[i] = (state_q == ST_ACTIVE);

    // State register
    always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) state_q <= ST_IDLE;
      else           state_q <= state_d;
    end

    if (EDGE_MASK[i]) begin : g_edge
      localparam int unsigned    CNT_W   = $clog2(MAX_PENDING + 1);
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

      logic             prev_q;
      logic             inc_c;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Previous synchronised sample and pending counter
      always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
          prev_q <= 1'b0;
          cnt_q  <= '0;
        end else begin
          prev_q <= sync_s;
          cnt_q  <= cnt_d;
        end
      end

      // Edges while disabled are dropped, never counted
      assign inc_c = sync_s & ~prev_q & irq_enable_i[i];

      // Next state, counter and overflow set
      always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ovf_set_c[i] = 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (irq_enable_i[i] && (cnt_q != '0)) begin
              // Serve a pending edge; a simultaneous new edge replaces it
              state_d = ST_ACTIVE;
              if (!inc_c) cnt_d = cnt_q - CNT_W'(1);
            end else if (inc_c) begin
              // Empty counter: the edge is served directly, not counted
              state_d = ST_ACTIVE;
            end
          end
          ST_ACTIVE: begin
            if (done_c) state_d = ST_IDLE;
            if (inc_c) begin
              if (cnt_q == CNT_MAX) ovf_set_c[i] = 1'b1;
              else                  cnt_d        = cnt_q + CNT_W'(1);
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else begin : g_level
      // Next state: level request held until completion
      always_comb begin
        state_d      = state_q;
        ovf_set_c[i] = 1'b0;
        case (state_q)
          ST_IDLE:   if (sync_s && irq_enable_i[i]) state_d = ST_ACTIVE;
          ST_ACTIVE: if (done_c)                    state_d = ST_IDLE;
          default:   state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Sticky overflow flags; a new overflow beats a coincident clear
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) overflow_q <= '0;
    else           overflow_q <= (overflow_q & ~{NUM_SRC{overflow_clear_i}}) | ovf_set_c;
  end

  assign overflow_o = overflow_q;

  // Map source states onto PLIC lines; line 0 and unmapped lines stay low
  for (genvar l = 0; l < NUM_PLIC_LINES; l++) begin : g_line
    if ((l >= SRC_BASE_LINE) && (l < SRC_BASE_LINE + NUM_SRC)) begin : g_map
      assign plic_irq_o[l] = active[l - SRC_BASE_LINE];
    end else begin : g_zero
      assign plic_irq_o[l] = 1'b0;
    end
  end

endmodule

// File: tb/tb_plic_irq_gateway.sv
// Testbench for plic_irq_gateway: sources 0,1 level mode, sources 2,3 edge mode,
// lines 1..4. Table-driven per-cycle vectors with a scoreboard queue, plus a
// hand-written reset-while-busy sequence.
module tb_plic_irq_gateway;

  logic        clk;
  logic        rst_n;
  logic [3:0]  irq_src;
  logic [3:0]  irq_enable;
  logic [31:0] plic_irq;
  logic        complete_valid;
  logic [4:0]  complete_id;
  logic [3:0]  overflow;
  logic        overflow_clear;

  plic_irq_gateway #(
    .NUM_SRC        (4),
    .NUM_PLIC_LINES (32),
    .SRC_BASE_LINE  (1),
    .EDGE_MASK      (4'b1100),
    .SYNC_STAGES    (2),
    .MAX_PENDING    (3)
  ) dut (
    .clock_i          (clk),
    .reset_ni         (rst_n),
    .irq_src_i        (irq_src),
    .irq_enable_i     (irq_enable),
    .plic_irq_o       (plic_irq),
    .complete_valid_i (complete_valid),
    .complete_id_i    (complete_id),
    .overflow_o       (overflow),
    .overflow_clear_i (overflow_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] src;
    logic [3:0] en;
    logic       cv;
    logic [4:0] cid;
    logic       clr;
    int         reps;
    logic [3:0] lines;   // expected state of PLIC lines 4..1
    logic [3:0] ovf;
    int         tag;
  } vec_t;

  typedef struct {
    logic [31:0] plic;
    logic [3:0]  ovf;
    int          tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   row   = 0;

  task automatic add(input int tag, input logic [3:0] src, input logic [3:0] en,
                     input logic cv, input logic [4:0] cid, input logic clr,
                     input int reps, input logic [3:0] lines, input logic [3:0] ovf);
    vec_t v;
    v.src = src; v.en = en; v.cv = cv; v.cid = cid; v.clr = clr;
    v.reps = reps; v.lines = lines; v.ovf = ovf; v.tag = tag;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int tag,
                       input logic [31:0] exp_plic, input logic [3:0] exp_ovf);
    total++;
    if (plic_irq !== exp_plic || overflow !== exp_ovf) begin
      bad++;
      $display("FAIL %s sec%0d row%0d: plic=%h ovf=%b, want plic=%h ovf=%b",
               name, tag, row, plic_irq, overflow, exp_plic, exp_ovf);
    end
  endtask

  // Drive one vector (reps cycles), queue its expectation, compare after the edge
  task automatic apply(input vec_t v);
    exp_t e, got;
    for (int r = 0; r < v.reps; r++) begin
      @(negedge clk);
      irq_src        = v.src;
      irq_enable     = v.en;
      complete_valid = v.cv;
      complete_id    = v.cid;
      overflow_clear = v.clr;
      e.plic         = '0;
      e.plic[4:1]    = v.lines;
      e.ovf          = v.ovf;
      e.tag          = v.tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty sec%0d row%0d: queue size 0, want 1", v.tag, row);
      end else begin
        got = sb.pop_front();
        check("vec", got.tag, got.plic, got.ovf);
      end
      row++;
    end
  endtask

  task automatic step(input logic [3:0] src, input logic [3:0] lines, input logic [3:0] ovf);
    vec_t v;
    v.src = src; v.en = 4'hF; v.cv = 1'b0; v.cid = '0; v.clr = 1'b0;
    v.reps = 1; v.lines = lines; v.ovf = ovf; v.tag = 6;
    apply(v);
  endtask

  initial begin
    // Section 1: level source 0, hold, complete, re-request, release
    add(1, 4'h1, 4'hF, 0, 0, 0, 2, 4'h0, 4'h0);
    add(1, 4'h1, 4'hF, 0, 0, 0, 8, 4'h1, 4'h0);
    add(1, 4'h1, 4'hF, 1, 1, 0, 1, 4'h0, 4'h0);
    add(1, 4'h1, 4'hF, 0, 0, 0, 1, 4'h1, 4'h0);
    add(1, 4'h0, 4'hF, 0, 0, 0, 2, 4'h1, 4'h0);
    add(1, 4'h0, 4'hF, 1, 1, 0, 1, 4'h0, 4'h0);
    add(1, 4'h0, 4'hF, 0, 0, 0, 3, 4'h0, 4'h0);
    // Section 2: edge source 2, three pulses while active, three services
    add(2, 4'h4, 4'hF, 0, 0, 0, 1, 4'h0, 4'h0);
    add(2, 4'h0, 4'hF, 0, 0, 0, 1, 4'h0, 4'h0);
    add(2, 4'h0, 4'hF, 0, 0, 0, 2, 4'h4, 4'h0);
    add(2, 4'h4, 4'hF, 0, 0, 0, 1, 4'h4, 4'h0);
    add(2, 4'h0, 4'hF, 0, 0, 0, 3, 4'h4, 4'h0);
    add(2, 4'h4, 4'hF, 0, 0, 0, 1, 4'h4, 4'h0);
    add(2, 4'h0, 4'hF, 0, 0, 0, 3, 4'h4, 4'h0);
    add(2, 4'h0, 4'hF, 1, 3, 0, 1, 4'h0, 4'h0);
    add(2, 4'h0, 4'hF, 0, 0, 0, 2, 4'h4, 4'h0);
    add(2, 4'h0, 4'hF, 1, 3, 0, 1, 4'h0, 4'h0);
    add(2, 4'h0, 4'hF, 0, 0, 0, 1, 4'h4, 4'h0);
    add(2, 4'h0, 4'hF, 1, 3, 0, 1, 4'h0, 4'h0);
    add(2, 4'h0, 4'hF, 0, 0, 0, 2, 4'h0, 4'h0);
    // Section 3: edge source 3 saturation, overflow, clear, clear vs new overflow
    add(3, 4'h8, 4'hF, 0, 0, 0, 1, 4'h0, 4'h0);
    add(3, 4'h0, 4'hF, 0, 0, 0, 1, 4'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      add(3, 4'h8, 4'hF, 0, 0, 0, 1, 4'h8, 4'h0);
      add(3, 4'h0, 4'hF, 0, 0, 0, 1, 4'h8, 4'h0);
    end
    add(3, 4'h0, 4'hF, 0, 0, 0, 2, 4'h8, 4'h8);
    add(3, 4'h0, 4'hF, 0, 0, 1, 1, 4'h8, 4'h0);
    add(3, 4'h8, 4'hF, 0, 0, 0, 1, 4'h8, 4'h0);
    add(3, 4'h0, 4'hF, 0, 0, 0, 1, 4'h8, 4'h0);
    add(3, 4'h0, 4'hF, 0, 0, 1, 1, 4'h8, 4'h8);
    add(3, 4'h0, 4'hF, 0, 0, 0, 1, 4'h8, 4'h8);
    for (int k = 0; k < 3; k++) begin
      add(3, 4'h0, 4'hF, 1, 4, 0, 1, 4'h0, 4'h8);
      add(3, 4'h0, 4'hF, 0, 0, 0, 1, 4'h8, 4'h8);
    end
    add(3, 4'h0, 4'hF, 1, 4, 0, 1, 4'h0, 4'h8);
    add(3, 4'h0, 4'hF, 0, 0, 0, 2, 4'h0, 4'h8);
    add(3, 4'h0, 4'hF, 0, 0, 1, 1, 4'h0, 4'h0);
    // Section 4: enable low ignores level and edge; enable dropped while active
    add(4, 4'h5, 4'h0, 0, 0, 0, 1, 4'h0, 4'h0);
    add(4, 4'h1, 4'h0, 0, 0, 0, 5, 4'h0, 4'h0);
    add(4, 4'h0, 4'h0, 0, 0, 0, 2, 4'h0, 4'h0);
    add(4, 4'h0, 4'hF, 0, 0, 0, 3, 4'h0, 4'h0);
    add(4, 4'h2, 4'hF, 0, 0, 0, 2, 4'h0, 4'h0);
    add(4, 4'h2, 4'hF, 0, 0, 0, 1, 4'h2, 4'h0);
    add(4, 4'h0, 4'h0, 0, 0, 0, 4, 4'h2, 4'h0);
    add(4, 4'h0, 4'h0, 1, 2, 0, 1, 4'h0, 4'h0);
    add(4, 4'h0, 4'h0, 0, 0, 0, 1, 4'h0, 4'h0);
    add(4, 4'h0, 4'hF, 0, 0, 0, 2, 4'h0, 4'h0);
    // Section 5: ignored completions, then complete one of two active lines
    add(5, 4'h3, 4'hF, 0, 0, 0, 2, 4'h0, 4'h0);
    add(5, 4'h3, 4'hF, 0, 0, 0, 1, 4'h3, 4'h0);
    add(5, 4'h0, 4'hF, 1, 0, 0, 1, 4'h3, 4'h0);
    add(5, 4'h0, 4'hF, 1, 7, 0, 1, 4'h3, 4'h0);
    add(5, 4'h0, 4'hF, 1, 3, 0, 1, 4'h3, 4'h0);
    add(5, 4'h0, 4'hF, 1, 31, 0, 1, 4'h3, 4'h0);
    add(5, 4'h0, 4'hF, 1, 1, 0, 1, 4'h2, 4'h0);
    add(5, 4'h0, 4'hF, 0, 2, 0, 1, 4'h2, 4'h0);
    add(5, 4'h0, 4'hF, 1, 2, 0, 1, 4'h0, 4'h0);
    add(5, 4'h0, 4'hF, 0, 0, 0, 1, 4'h0, 4'h0);

    // Reset state
    rst_n          = 1'b0;
    irq_src        = '0;
    irq_enable     = '0;
    complete_valid = 1'b0;
    complete_id    = '0;
    overflow_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 0, 32'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset", 0, 32'h0, 4'h0);

    foreach (vecs[n]) apply(vecs[n]);

    // Section 6: reset while source 2 is active with two pending, source 3 overflowed
    step(4'hC, 4'h0, 4'h0);
    step(4'h0, 4'h0, 4'h0);
    step(4'hC, 4'hC, 4'h0);
    step(4'h0, 4'hC, 4'h0);
    step(4'hC, 4'hC, 4'h0);
    step(4'h0, 4'hC, 4'h0);
    step(4'h8, 4'hC, 4'h0);
    step(4'h0, 4'hC, 4'h0);
    step(4'h8, 4'hC, 4'h0);
    step(4'h0, 4'hC, 4'h0);
    step(4'h0, 4'hC, 4'h8);
    step(4'h0, 4'hC, 4'h8);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", 6, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    check("reset_held", 6, 32'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) step(4'h0, 4'h0, 4'h0);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: queue size %0d, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
